// File: rtl/diag_pkg.sv
// Shared constants and types for the MISR signature diagnoser.
// Holds result codes, FSM encoding and default dimensions.
package diag_pkg;

    localparam int DEF_SIG_WIDTH  = 14;
    localparam int DEF_NUM_FAULTS = 1317;
    localparam int DEF_IDX_W      = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        PASS    = 2'd0,
        UNIQUE  = 2'd1,
        ALIASED = 2'd2,
        UNKNOWN = 2'd3
    } result_t;

    // Verdict for a non-passing diagnosis from its match count.
    function automatic result_t classify(input int n);
        if (n == 0)
            return UNKNOWN;
        else if (n == 1)
            return UNIQUE;
        else
            return ALIASED;
    endfunction

endpackage

// File: rtl/dict_ram.sv
// Fault dictionary storage: one write port, one synchronous read port.
// Contents are deliberately not reset; validity is tracked outside.
module dict_ram #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 1317,
    parameter int AW    = 11
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             re,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port: store a faulty signature.
    always_ff @(posedge clk) begin
        if (we)
            mem[wr_addr] <= wr_data;
    end

    // Read port: data appears one cycle after the address.
    always_ff @(posedge clk) begin
        if (re)
            rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/sig_diagnoser.sv
// Compares an observed MISR signature against a golden value and
// scans a fault dictionary, reporting every matching fault index.
module sig_diagnoser
    import diag_pkg::*;
#(
    parameter int SIG_WIDTH  = DEF_SIG_WIDTH,
    parameter int NUM_FAULTS = DEF_NUM_FAULTS,
    parameter int IDX_W      = DEF_IDX_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 gold_we,
    input  logic [SIG_WIDTH-1:0] gold_sig,
    input  logic                 wr_en,
    input  logic [IDX_W-1:0]     wr_idx,
    input  logic [SIG_WIDTH-1:0] wr_sig,
    input  logic                 start,
    input  logic [SIG_WIDTH-1:0] obs_sig,
    output logic                 busy,
    output logic                 match_valid,
    output logic [IDX_W-1:0]     match_idx,
    output logic                 done,
    output logic [1:0]           result,
    output logic [IDX_W:0]       match_count,
    output logic [IDX_W-1:0]     first_idx
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FAULTS - 1);
    localparam logic [IDX_W:0]   CNT_MAX  = (IDX_W + 1)'(NUM_FAULTS);

    state_t                 state;
    state_t                 nxt;
    logic                   in_idle;
    logic                   rd_en;
    logic                   done_set;
    logic                   start_ok;
    logic                   wr_ok;
    logic                   gold_ok;
    logic                   pass_now;
    logic                   pass_q;
    logic                   hit;
    logic [SIG_WIDTH-1:0]   gold_q;
    logic [SIG_WIDTH-1:0]   obs_q;
    logic [SIG_WIDTH-1:0]   rd_data;
    logic [IDX_W-1:0]       scan_idx;
    logic [IDX_W-1:0]       idx_q;
    logic                   cmp_v_q;
    logic                   vbit_q;
    logic [NUM_FAULTS-1:0]  vld;
    logic [IDX_W:0]         cnt;
    logic [IDX_W-1:0]       first_run;
    result_t                res_q;
    logic [IDX_W:0]         cnt_q;
    logic [IDX_W-1:0]       first_q;

    // A new golden value written together with start takes part
    // in the PASS check of that very request.
    assign start_ok = in_idle & start;
    assign gold_ok  = in_idle & gold_we;
    assign wr_ok    = in_idle & wr_en & (int'(wr_idx) < NUM_FAULTS);
    assign pass_now = obs_sig == (gold_we ? gold_sig : gold_q);

    assign hit         = cmp_v_q & vbit_q & (rd_data == obs_q);
    assign match_valid = hit;
    assign match_idx   = idx_q;
    assign result      = res_q;
    assign match_count = cnt_q;
    assign first_idx   = first_q;

    dict_ram #(
        .WIDTH (SIG_WIDTH),
        .DEPTH (NUM_FAULTS),
        .AW    (IDX_W)
    ) u_ram (
        .clk     (clk),
        .we      (wr_ok),
        .wr_addr (wr_idx),
        .wr_data (wr_sig),
        .re      (rd_en),
        .rd_addr (scan_idx),
        .rd_data (rd_data)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= nxt;
    end

    // Next-state: PASS skips the scan; FLUSH compares the last entry.
    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (start) nxt = pass_now ? DONE : SCAN;
            SCAN:    if (scan_idx == LAST_IDX) nxt = FLUSH;
            FLUSH:   nxt = DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // State decode for handshake and datapath enables.
    always_comb begin
        in_idle  = state == IDLE;
        busy     = state != IDLE;
        rd_en    = state == SCAN;
        done_set = state == DONE;
    end

    // Valid bits distinguish written entries from stale RAM data.
    always_ff @(posedge clk) begin
        if (reset)
            vld <= '0;
        else if (wr_ok)
            vld[wr_idx] <= 1'b1;
    end

    // Request capture, scan address and running match statistics.
    always_ff @(posedge clk) begin
        if (reset) begin
            gold_q    <= '0;
            obs_q     <= '0;
            pass_q    <= 1'b0;
            scan_idx  <= '0;
            cnt       <= '0;
            first_run <= '0;
        end else begin
            if (gold_ok)
                gold_q <= gold_sig;
            if (start_ok) begin
                obs_q     <= obs_sig;
                pass_q    <= pass_now;
                scan_idx  <= '0;
                cnt       <= '0;
                first_run <= '0;
            end else if (rd_en) begin
                scan_idx <= scan_idx + IDX_W'(1);
            end
            if (hit) begin
                if (cnt != CNT_MAX)
                    cnt <= cnt + (IDX_W + 1)'(1);
                if (cnt == '0)
                    first_run <= idx_q;
            end
        end
    end

    // Align valid bit and index with the RAM read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmp_v_q <= 1'b0;
            vbit_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            cmp_v_q <= rd_en;
            if (rd_en) begin
                vbit_q <= vld[scan_idx];
                idx_q  <= scan_idx;
            end
        end
    end

    // Publish the verdict with done and hold it until the next one.
    always_ff @(posedge clk) begin
        if (reset) begin
            done    <= 1'b0;
            res_q   <= UNKNOWN;
            cnt_q   <= '0;
            first_q <= '0;
        end else begin
            done <= done_set;
            if (done_set) begin
                res_q   <= pass_q ? PASS : classify(int'(cnt));
                cnt_q   <= pass_q ? '0 : cnt;
                first_q <= first_run;
            end
        end
    end

endmodule

// File: tb/tb_sig_diagnoser.sv
// Self-checking bench for sig_diagnoser: table-driven queries with a
// scoreboard of expected match indices, plus multi-cycle sequences.
module tb_sig_diagnoser;

    localparam int N  = 1317;
    localparam int SW = 14;
    localparam int IW = 11;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          gold_we = 1'b0;
    logic [SW-1:0] gold_sig = '0;
    logic          wr_en = 1'b0;
    logic [IW-1:0] wr_idx = '0;
    logic [SW-1:0] wr_sig = '0;
    logic          start = 1'b0;
    logic [SW-1:0] obs_sig = '0;
    logic          busy;
    logic          match_valid;
    logic [IW-1:0] match_idx;
    logic          done;
    logic [1:0]    result;
    logic [IW:0]   match_count;
    logic [IW-1:0] first_idx;

    sig_diagnoser #(
        .SIG_WIDTH  (SW),
        .NUM_FAULTS (N),
        .IDX_W      (IW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .gold_we     (gold_we),
        .gold_sig    (gold_sig),
        .wr_en       (wr_en),
        .wr_idx      (wr_idx),
        .wr_sig      (wr_sig),
        .start       (start),
        .obs_sig     (obs_sig),
        .busy        (busy),
        .match_valid (match_valid),
        .match_idx   (match_idx),
        .done        (done),
        .result      (result),
        .match_count (match_count),
        .first_idx   (first_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [SW-1:0] obs;
        int            res;
        int            cnt;
        int            first;
        int            lat;
    } vec_t;

    int            nchk = 0;
    int            nerr = 0;
    logic [SW-1:0] m_sig [N];
    bit            m_vld [N];
    logic [SW-1:0] m_gold = '0;
    int            sb [$];
    vec_t          tbl [6];

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < N; i++) m_vld[i] = 1'b0;
        m_gold = '0;
    endtask

    task automatic wr(input int idx, input logic [SW-1:0] s);
        @(negedge clk);
        wr_en  = 1'b1;
        wr_idx = idx[IW-1:0];
        wr_sig = s;
        @(posedge clk);
        #1 wr_en = 1'b0;
        if (idx < N) begin
            m_sig[idx] = s;
            m_vld[idx] = 1'b1;
        end
    endtask

    task automatic set_gold(input logic [SW-1:0] g);
        @(negedge clk);
        gold_we  = 1'b1;
        gold_sig = g;
        @(posedge clk);
        #1 gold_we = 1'b0;
        m_gold = g;
    endtask

    // Launch one diagnosis and check pulses and verdict. k counts
    // falling edges after the start edge; a signal seen at k is
    // sampled by rising edge k+1 after start.
    task automatic run_query(
        input string         nm,
        input logic [SW-1:0] obs,
        input int            eres,
        input int            ecnt,
        input int            efirst,
        input int            elat,
        input bit            co_wr,
        input int            co_idx,
        input logic [SW-1:0] co_sig,
        input bit            co_gold,
        input logic [SW-1:0] co_gval,
        input bit            inj
    );
        int k;
        int e;
        int extra;
        bit got;
        @(negedge clk);
        start   = 1'b1;
        obs_sig = obs;
        if (co_wr) begin
            wr_en  = 1'b1;
            wr_idx = co_idx[IW-1:0];
            wr_sig = co_sig;
            m_sig[co_idx] = co_sig;
            m_vld[co_idx] = 1'b1;
        end
        if (co_gold) begin
            gold_we  = 1'b1;
            gold_sig = co_gval;
            m_gold   = co_gval;
        end
        sb.delete();
        if (obs != m_gold)
            for (int i = 0; i < N; i++)
                if (m_vld[i] && m_sig[i] == obs) sb.push_back(i);
        @(posedge clk);
        #1;
        start   = 1'b0;
        wr_en   = 1'b0;
        gold_we = 1'b0;
        got = 1'b0;
        k = 0;
        while (!got && k < N + 20) begin
            @(negedge clk);
            if (inj && k == 50) begin
                start    = 1'b1;
                obs_sig  = 14'h3C3;
                wr_en    = 1'b1;
                wr_idx   = 11'd5;
                wr_sig   = 14'h3C3;
                gold_we  = 1'b1;
                gold_sig = 14'h3C3;
            end
            if (inj && k == 51) begin
                start   = 1'b0;
                wr_en   = 1'b0;
                gold_we = 1'b0;
            end
            if (k == 0) chk({nm, " busy_after_start"}, int'(busy), 1);
            if (match_valid) begin
                if (sb.size() == 0) begin
                    chk({nm, " unexpected_match"}, int'(match_idx), -1);
                end else begin
                    e = sb.pop_front();
                    chk({nm, " match_idx"}, int'(match_idx), e);
                    chk({nm, " match_time"}, k, e + 1);
                end
            end
            if (done) begin
                got = 1'b1;
                chk({nm, " done_latency"}, k + 1, elat);
                chk({nm, " busy_at_done"}, int'(busy), 0);
                chk({nm, " result"}, int'(result), eres);
                chk({nm, " match_count"}, int'(match_count), ecnt);
                chk({nm, " first_idx"}, int'(first_idx), efirst);
                chk({nm, " missing_matches"}, sb.size(), 0);
            end
            k++;
        end
        if (!got) chk({nm, " done_timeout"}, 0, 1);
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        chk({nm, " quiet_after_done"}, extra, 0);
    endtask

    initial begin
        int nd;
        int nm;
        tbl[0] = '{14'h1A5, 0, 0, 0, 2};
        tbl[1] = '{14'h0F0, 1, 1, 7, N + 3};
        tbl[2] = '{14'h333, 1, 1, 9, N + 3};
        tbl[3] = '{14'h2AA, 2, 3, 3, N + 3};
        tbl[4] = '{14'h3FF, 3, 0, 0, N + 3};
        tbl[5] = '{14'h155, 1, 1, 0, N + 3};

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Stale RAM word at index 20 must not count after reset.
        wr(20, 14'h3FF);
        do_reset();
        @(negedge clk);
        chk("rst busy", int'(busy), 0);
        chk("rst done", int'(done), 0);
        chk("rst match_valid", int'(match_valid), 0);
        chk("rst match_idx", int'(match_idx), 0);
        chk("rst result", int'(result), 3);
        chk("rst match_count", int'(match_count), 0);
        chk("rst first_idx", int'(first_idx), 0);

        set_gold(14'h1A5);
        wr(0, 14'h155);
        wr(7, 14'h0F0);
        wr(9, 14'h333);
        wr(3, 14'h2AA);
        wr(500, 14'h2AA);
        wr(N - 1, 14'h2AA);
        wr(1400, 14'h0F0);

        for (int v = 0; v < 6; v++)
            run_query($sformatf("vec%0d", v), tbl[v].obs, tbl[v].res,
                      tbl[v].cnt, tbl[v].first, tbl[v].lat,
                      0, 0, '0, 0, '0, 0);

        run_query("co_write", 14'h0AB, 1, 1, 100, N + 3,
                  1, 100, 14'h0AB, 0, '0, 0);
        run_query("co_gold", 14'h222, 0, 0, 0, 2,
                  0, 0, '0, 1, 14'h222, 0);
        run_query("busy_inject", 14'h0F0, 1, 1, 7, N + 3,
                  0, 0, '0, 0, '0, 1);
        run_query("after_inject", 14'h3C3, 3, 0, 0, N + 3,
                  0, 0, '0, 0, '0, 0);

        // Reset in the middle of a scan aborts it silently.
        @(negedge clk);
        start   = 1'b1;
        obs_sig = 14'h2AA;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (100) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < N; i++) m_vld[i] = 1'b0;
        m_gold = '0;
        @(negedge clk);
        chk("abort busy", int'(busy), 0);
        chk("abort result", int'(result), 3);
        chk("abort match_count", int'(match_count), 0);
        nd = 0;
        nm = 0;
        repeat (N + 10) begin
            @(negedge clk);
            if (done) nd++;
            if (match_valid) nm++;
        end
        chk("abort no_done", nd, 0);
        chk("abort no_match", nm, 0);

        run_query("requery", 14'h0F0, 3, 0, 0, N + 3,
                  0, 0, '0, 0, '0, 0);
        wr(7, 14'h0F0);
        run_query("rewritten", 14'h0F0, 1, 1, 7, N + 3,
                  0, 0, '0, 0, '0, 0);

        // Every entry aliases: largest possible count.
        for (int i = 0; i < N; i++) wr(i, 14'h111);
        run_query("all_alias", 14'h111, 2, N, 0, N + 3,
                  0, 0, '0, 0, '0, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 nchk, nerr);
        $finish;
    end

endmodule
